// File: rtl/irq_ctrl_plic_lite.sv
// PLIC-style interrupt controller: per-source gateway (edge/level), priority arbitration
// against a threshold, and a claim/complete handshake over a word-addressed MMIO port.
module irq_ctrl_plic_lite #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   irq_src,
  output logic              interrupt,
  input  logic [4:0]        a,
  input  logic [31:0]       d,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       spo
);

  localparam logic [4:0] ID_MAX = 5'(NSRC);

  logic [NSRC-1:0]   sync1;
  logic [NSRC-1:0]   sync2;
  logic [NSRC-1:0]   hist;
  logic [NSRC-1:0]   pend;
  logic [NSRC-1:0]   inservice;
  logic [NSRC-1:0]   enable;
  logic [NSRC-1:0]   mode;
  logic [PRIO_W-1:0] threshold;
  logic [PRIO_W-1:0] prio [NSRC];

  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   eligible;
  logic [NSRC-1:0]   claim_mask;
  logic [NSRC-1:0]   complete_mask;
  logic [4:0]        best_id;
  logic [PRIO_W-1:0] best_prio;
  logic              claim_fire;
  logic              complete_fire;
  logic              prio_sel;
  logic [3:0]        prio_idx;
  logic              unused_d;

  assign unused_d      = ^d;
  assign rise          = sync2 & ~hist;
  assign claim_fire    = re && (a == 5'd4) && (best_id != 5'd0);
  assign complete_fire = we && (a == 5'd4);
  assign prio_sel      = a[4] && ({1'b0, a[3:0]} < ID_MAX);
  assign prio_idx      = a[3:0];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NSRC; i++) begin
      eligible[i] = pend[i] & enable[i] & ~inservice[i] & (prio[i] > threshold);
    end
  end

  // Strict '>' keeps the lowest index on a priority tie.
  always_comb begin
    best_id   = 5'd0;
    best_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i] && ((best_id == 5'd0) || (prio[i] > best_prio))) begin
        best_id   = 5'(i + 1);
        best_prio = prio[i];
      end
    end
  end

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_mask[i]    = claim_fire && (best_id == 5'(i + 1));
      complete_mask[i] = complete_fire && (d[4:0] == 5'(i + 1));
    end
  end

  always_comb begin
    spo = '0;
    case (a)
      5'd0: spo = 32'(enable);
      5'd1: spo = 32'(pend);
      5'd2: spo = 32'(mode);
      5'd3: spo = 32'(threshold);
      5'd4: spo = 32'(best_id);
      5'd5: spo = 32'(inservice);
      default: begin
        for (int i = 0; i < NSRC; i++) begin
          if (prio_sel && (prio_idx == 4'(i))) spo = 32'(prio[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      hist      <= '0;
      pend      <= '0;
      inservice <= '0;
      enable    <= '0;
      mode      <= '0;
      threshold <= '0;
      interrupt <= 1'b0;
      for (int i = 0; i < NSRC; i++) prio[i] <= PRIO_W'(1);
    end else begin
      sync1     <= irq_src;
      sync2     <= sync1;
      hist      <= sync2;
      interrupt <= (best_id != 5'd0);

      if (we) begin
        case (a)
          5'd0:    enable    <= d[NSRC-1:0];
          5'd2:    mode      <= d[NSRC-1:0];
          5'd3:    threshold <= d[PRIO_W-1:0];
          default: ;
        endcase
      end
      for (int i = 0; i < NSRC; i++) begin
        if (we && prio_sel && (prio_idx == 4'(i))) prio[i] <= d[PRIO_W-1:0];
      end

      inservice <= (inservice & ~complete_mask) | claim_mask;

      // Edge: a new rise beats the claim clear. Level: the claim clears pend, and the
      // line is only re-sampled once the source leaves service.
      for (int i = 0; i < NSRC; i++) begin
        if (mode[i])                pend[i] <= rise[i] | (pend[i] & ~claim_mask[i]);
        else if (claim_mask[i])     pend[i] <= 1'b0;
        else if (!inservice[i])     pend[i] <= sync2[i];
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl_plic_lite.sv
// Directed bench for irq_ctrl_plic_lite: gateway timing, arbitration, threshold,
// claim/complete handshake and reset.
module tb_irq_ctrl_plic_lite;
  localparam int NSRC   = 8;
  localparam int PRIO_W = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq_src;
  logic            interrupt;
  logic [4:0]      a;
  logic [31:0]     d;
  logic            we;
  logic            re;
  logic [31:0]     spo;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  irq_ctrl_plic_lite #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .interrupt(interrupt),
    .a(a), .d(d), .we(we), .re(re), .spo(spo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    a = addr; d = data; we = 1'b1;
    tick();
    we = 1'b0; d = '0; a = '0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    check(tag, spo, exp);
    a = '0;
  endtask

  task automatic claim(input string tag, input logic [31:0] exp);
    a = 5'd4; re = 1'b1;
    #1;
    check(tag, spo, exp);
    tick();
    re = 1'b0; a = '0;
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; a = '0; d = '0; we = 1'b0; re = 1'b0;
    tick(2);
    check("rst_irq_held", interrupt, 0);
    rst = 1'b0;
    rd_check("rst_enable", 5'd0, 0);
    rd_check("rst_pend", 5'd1, 0);
    rd_check("rst_mode", 5'd2, 0);
    rd_check("rst_thr", 5'd3, 0);
    rd_check("rst_claim", 5'd4, 0);
    rd_check("rst_insvc", 5'd5, 0);
    rd_check("rst_unmapped", 5'd6, 0);
    rd_check("rst_prio0", 5'd16, 1);
    rd_check("rst_prio7", 5'd23, 1);

    // 1: edge pulse on src0, 3-cycle pend latency, interrupt on the 4th edge
    wr(5'd0, 32'h01);
    wr(5'd2, 32'h01);
    irq_src = 8'h01; tick();
    irq_src = 8'h00; tick(2);
    check("t1_irq_e3", interrupt, 0);
    rd_check("t1_pend_e3", 5'd1, 32'h01);
    tick();
    check("t1_irq_e4", interrupt, 1);
    claim("t1_claim", 1);
    rd_check("t1_insvc", 5'd5, 32'h01);
    rd_check("t1_pend_clr", 5'd1, 0);
    tick();
    check("t1_irq_drop", interrupt, 0);
    wr(5'd4, 32'd1);
    rd_check("t1_complete", 5'd5, 0);

    // 2: priority order with a tie between ID3 and ID6
    wr(5'd18, 32'd5);
    wr(5'd21, 32'd5);
    wr(5'd17, 32'd3);
    wr(5'd0, 32'hFF);
    wr(5'd2, 32'hFF);
    irq_src = 8'h26; tick(4);
    check("t2_irq", interrupt, 1);
    rd_check("t2_pend", 5'd1, 32'h26);
    claim("t2_c1", 3);
    wr(5'd4, 32'd3);
    claim("t2_c2", 6);
    wr(5'd4, 32'd6);
    claim("t2_c3", 2);
    wr(5'd4, 32'd2);
    claim("t2_c4", 0);
    irq_src = 8'h00; tick(4);
    rd_check("t2_pend_end", 5'd1, 0);
    rd_check("t2_insvc_end", 5'd5, 0);
    check("t2_irq_end", interrupt, 0);

    // 3: threshold blocks equal priority, lowering it releases the request
    wr(5'd0, 32'h00);
    wr(5'd2, 32'h00);
    wr(5'd3, 32'd4);
    wr(5'd19, 32'd4);
    wr(5'd0, 32'h08);
    irq_src = 8'h08; tick(5);
    check("t3_irq_blocked", interrupt, 0);
    rd_check("t3_pend", 5'd1, 32'h08);
    wr(5'd3, 32'd3);
    check("t3_irq_at_write", interrupt, 0);
    tick();
    check("t3_irq_released", interrupt, 1);
    claim("t3_claim", 4);
    irq_src = 8'h00; tick(3);
    wr(5'd4, 32'd4);
    tick(2);
    rd_check("t3_pend_end", 5'd1, 0);
    rd_check("t3_insvc_end", 5'd5, 0);
    wr(5'd3, 32'd0);

    // 4: level source re-pends after complete while held; not once dropped
    wr(5'd0, 32'h01);
    irq_src = 8'h01; tick(4);
    check("t4_irq", interrupt, 1);
    claim("t4_claim1", 1);
    tick();
    check("t4_irq_insvc", interrupt, 0);
    rd_check("t4_pend_insvc", 5'd1, 0);
    wr(5'd4, 32'd1);
    check("t4_irq_at_complete", interrupt, 0);
    tick(2);
    check("t4_irq_repend", interrupt, 1);
    claim("t4_claim2", 1);
    irq_src = 8'h00; tick(3);
    wr(5'd4, 32'd1);
    tick(3);
    check("t4_irq_dropped", interrupt, 0);
    rd_check("t4_pend_dropped", 5'd1, 0);

    // 5: edges while in service collapse into one pending request
    wr(5'd0, 32'h10);
    wr(5'd2, 32'h10);
    irq_src = 8'h10; tick();
    irq_src = 8'h00; tick(3);
    check("t5_irq", interrupt, 1);
    claim("t5_claim1", 5);
    repeat (2) begin
      irq_src = 8'h10; tick();
      irq_src = 8'h00; tick();
    end
    tick(3);
    rd_check("t5_pend_insvc", 5'd1, 32'h10);
    rd_check("t5_insvc", 5'd5, 32'h10);
    check("t5_irq_insvc", interrupt, 0);
    wr(5'd4, 32'd5);
    tick();
    check("t5_irq_after_complete", interrupt, 1);
    claim("t5_claim2", 5);
    wr(5'd4, 32'd5);
    claim("t5_claim3", 0);
    rd_check("t5_insvc_end", 5'd5, 0);
    rd_check("t5_pend_end", 5'd1, 0);

    // 6: invalid completes ignored; reset mid-service restores everything
    irq_src = 8'h10; tick();
    irq_src = 8'h00; tick(3);
    claim("t6_claim", 5);
    wr(5'd4, 32'd0);
    rd_check("t6_id0", 5'd5, 32'h10);
    wr(5'd4, 32'd9);
    rd_check("t6_id_oor", 5'd5, 32'h10);
    wr(5'd4, 32'd2);
    rd_check("t6_id_not_insvc", 5'd5, 32'h10);
    wr(5'd0, 32'h11);
    wr(5'd2, 32'h11);
    irq_src = 8'h01; tick();
    irq_src = 8'h00; tick(3);
    check("t6_irq_pre_rst", interrupt, 1);
    wr(5'd3, 32'd2);
    rst = 1'b1; tick();
    check("t6_irq_rst", interrupt, 0);
    rst = 1'b0;
    rd_check("t6_enable", 5'd0, 0);
    rd_check("t6_pend", 5'd1, 0);
    rd_check("t6_mode", 5'd2, 0);
    rd_check("t6_thr", 5'd3, 0);
    rd_check("t6_insvc", 5'd5, 0);
    rd_check("t6_prio2", 5'd18, 1);
    rd_check("t6_prio3", 5'd19, 1);
    tick();
    check("t6_irq_after", interrupt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
